// File: rtl/turn_executor.sv
// Turn executor: converts one-shot turn trigger pulses into timed steering
// drive, followed by a settle period, with forward motion gated meanwhile.
module turn_executor #(
    parameter int TURN_90_TICKS  = 450,
    parameter int TURN_180_TICKS = 900,
    parameter int SETTLE_TICKS   = 25,
    parameter int CNT_W          = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic trigger_turn_left,
    input  logic trigger_turn_right,
    input  logic trigger_turn_back,
    input  logic move_forward_req,
    output logic is_turning,
    output logic out_forward,
    output logic out_turn_left,
    output logic out_turn_right,
    output logic turn_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TURN_L = 3'd1,
        TURN_R = 3'd2,
        TURN_B = 3'd3,
        SETTLE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_90     = CNT_W'(TURN_90_TICKS - 1);
    localparam logic [CNT_W-1:0] LAST_180    = CNT_W'(TURN_180_TICKS - 1);
    localparam logic [CNT_W-1:0] LAST_SETTLE = CNT_W'(SETTLE_TICKS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             left_hist_q, right_hist_q, back_hist_q;
    logic             is_turning_d, out_forward_d, out_turn_left_d;
    logic             out_turn_right_d, turn_done_d;
    logic             is_turning_q, out_forward_q, out_turn_left_q;
    logic             out_turn_right_q, turn_done_q;

    logic left_edge, right_edge, back_edge;
    assign left_edge  = trigger_turn_left  & ~left_hist_q;
    assign right_edge = trigger_turn_right & ~right_hist_q;
    assign back_edge  = trigger_turn_back  & ~back_hist_q;

    // State register, counter, trigger history and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            left_hist_q      <= 1'b0;
            right_hist_q     <= 1'b0;
            back_hist_q      <= 1'b0;
            is_turning_q     <= 1'b0;
            out_forward_q    <= 1'b0;
            out_turn_left_q  <= 1'b0;
            out_turn_right_q <= 1'b0;
            turn_done_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            left_hist_q      <= trigger_turn_left;
            right_hist_q     <= trigger_turn_right;
            back_hist_q      <= trigger_turn_back;
            is_turning_q     <= is_turning_d;
            out_forward_q    <= out_forward_d;
            out_turn_left_q  <= out_turn_left_d;
            out_turn_right_q <= out_turn_right_d;
            turn_done_q      <= turn_done_d;
        end
    end

    // Next-state and counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (back_edge)       state_d = TURN_B;
                    else if (left_edge)  state_d = TURN_L;
                    else if (right_edge) state_d = TURN_R;
                end
                TURN_L, TURN_R: begin
                    if (cnt_q == LAST_90) begin
                        state_d = SETTLE;
                        cnt_d   = '0;
                    end
                end
                TURN_B: begin
                    if (cnt_q == LAST_180) begin
                        state_d = SETTLE;
                        cnt_d   = '0;
                    end
                end
                SETTLE: begin
                    if (cnt_q == LAST_SETTLE) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the state being entered so they register with it
    always_comb begin
        is_turning_d     = 1'b0;
        out_forward_d    = 1'b0;
        out_turn_left_d  = 1'b0;
        out_turn_right_d = 1'b0;
        turn_done_d      = 1'b0;
        if (enable) begin
            case (state_d)
                IDLE: begin
                    out_forward_d = move_forward_req;
                    turn_done_d   = (state_q == SETTLE);
                end
                TURN_L: begin
                    is_turning_d    = 1'b1;
                    out_turn_left_d = 1'b1;
                end
                TURN_R, TURN_B: begin
                    is_turning_d     = 1'b1;
                    out_turn_right_d = 1'b1;
                end
                SETTLE:  is_turning_d = 1'b1;
                default: is_turning_d = 1'b0;
            endcase
        end
    end

    assign is_turning     = is_turning_q;
    assign out_forward    = out_forward_q;
    assign out_turn_left  = out_turn_left_q;
    assign out_turn_right = out_turn_right_q;
    assign turn_done      = turn_done_q;

endmodule
